seg_scan_driver: RTL
====================

# seg_scan_driver

Time-multiplexed four-digit seven-segment driver that sits directly downstream of the processor's 13-bit seven-segment result register. It latches each value the processor writes and displays it as hexadecimal with leading-zero blanking, scanning one digit at a time. New values are committed only at frame boundaries, so the display never tears mid-scan.

## Interface
- SCAN_DIV, default 50000: clk cycles each digit stays lit; legal range ≥2.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- value_in  in  13  value to display (processor seven-segment data).
- value_we  in  1  one-cycle write strobe; captures value_in.
- blank_en  in  1  1 = blank leading-zero digits.
- dp_mask  in  4  per-digit decimal point request, bit i = digit i.
- seg_n  out  7  segment cathodes {g,f,e,d,c,b,a}, active-low, registered.
- dp_n  out  1  decimal point, active-low, registered.
- an_n  out  4  digit anodes, active-low one-hot, registered.
- frame_tick  out  1  one-cycle pulse on the frame wrap cycle, registered.

## Operation
- Digit mapping:
  - digit0 = value[3:0]
  - digit1 = value[7:4]
  - digit2 = value[11:8]
  - digit3 = {3'b000, value[12]}
- Registers:
  - pending (13 b) and pending_valid: written when value_we=1; last write within a frame wins.
  - shown (13 b): the value actually scanned.
  - div_cnt (clog2(SCAN_DIV) b)
  - dig_idx (2 b)
- Scan:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - On terminal count, dig_idx increments modulo 4.
- Frame wrap (terminal count with dig_idx=3):
  - If value_we is asserted on this same cycle, shown <= value_in (write-through) and pending_valid <= 0.
  - Else if pending_valid, shown <= pending and pending_valid <= 0.
  - Else shown is held.
- Blanking, with blank_en=1:
  - digit3 is blanked if 0.
  - digit2 is blanked if digits 3..2 are all 0.
  - digit1 is blanked if digits 3..1 are all 0.
  - digit0 is never blanked.
  - A blanked digit drives seg_n=7'h7F; dp_n still follows dp_mask.
- Decode is standard hex, active-low, e.g.:
  - 0=7'b1000000, 1=7'b1111001, 8=7'b0000000
  - A=7'b0001000, b=7'b0000011, F=7'b0001110
- Output stage:
  - an_n <= ~(4'b0001 << dig_idx)
  - seg_n <= decode/blank(shown, dig_idx)
  - dp_n <= ~dp_mask[dig_idx]
- Unused code space: none. All 16 nibble codes decode.

## Timing
- Reset (async, immediate): div_cnt=0, dig_idx=0, shown=0, pending=0, pending_valid=0; an_n=4'b1111, seg_n=7'h7F, dp_n=1, frame_tick=0.
- First rising edge after rst_n release: an_n=4'b1110, seg_n=7'b1000000 (digit0 shows "0").
- Digit period is SCAN_DIV cycles; frame is 4*SCAN_DIV cycles.
- Outputs lag dig_idx/shown by exactly one cycle. An anode change and its segment change occur on the same edge.
- frame_tick is high the cycle after the frame-wrap edge, aligned with an_n returning to 4'b1110.
- value_we to visible latency:
  - Worst case one full frame plus 1 cycle.
  - Best case 1 cycle (write-through on the wrap cycle).
- dp_mask and blank_en are sampled each cycle. They are not frame-synchronised.
- Reset asserted mid-frame abandons the scan and discards pending; the sequence restarts from digit0.

## Structure
- Package seg_pkg holds:
  - SEG_BLANK = 7'h7F
  - a 16-entry active-low hex segment constant array
  - a function to compute SCAN_DIV counter width
- Sub-module hex7_decode: 4-bit nibble in, 7-bit active-low pattern out, purely combinational, instantiated once on the selected digit.

## Test plan
All scenarios use SCAN_DIV=4.
- Reset release, blank_en=0, no writes: an_n cycles 1110→1101→1011→0111 every 4 clk; seg_n=7'b1000000 on every digit; frame_tick pulses every 16 clk.
- value_we with 13'h1A5F mid-frame: display unchanged until the next frame; then digits 3..0 show 1, A, 5, F; latency ≤17 cycles.
- Two writes (13'h0123 then 13'h0456) in one frame: only 0456 is ever displayed. With blank_en=1, digit3 is blank and digits 2..0 show 4, 5, 6.
- value_we with 13'h0007 exactly on the wrap cycle, blank_en=1: the next frame shows digit0 = 7 and digits 3..1 = 7'h7F (write-through).
- dp_mask=4'b0100: dp_n=0 only while an_n=4'b1011.
- rst_n pulsed low while dig_idx=2 with a pending write: outputs go to reset values immediately; after release, shown=0 and the pending value never appears.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: blank pattern,
// active-low hex segment table and scan divider width helper.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for nibble codes 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic int div_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/hex7_decode.sv
// Combinational nibble to active-low seven-segment pattern.
module hex7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed hex display driver with leading-zero blanking.
// Written values are committed only at frame wrap so a scan never tears.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] value_in,
  input  logic        value_we,
  input  logic        blank_en,
  input  logic [3:0]  dp_mask,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_tick
);

  localparam int DIV_W = div_width(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       dig_idx;
  logic [12:0]      pending;
  logic [12:0]      shown;
  logic             pending_valid;
  logic             wrapped;
  logic             tc;
  logic             wrap;
  logic [3:0]       nibble;
  logic             blank;
  logic [6:0]       hex_seg;

  assign tc   = (div_cnt == DIV_LAST);
  assign wrap = tc && (dig_idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      dig_idx <= 2'd0;
      wrapped <= 1'b0;
    end else begin
      if (tc) begin
        div_cnt <= '0;
        dig_idx <= dig_idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      // Delayed one cycle so frame_tick lines up with digit0 on the outputs.
      wrapped <= wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending       <= '0;
      pending_valid <= 1'b0;
      shown         <= '0;
    end else if (wrap) begin
      if (value_we) begin
        shown <= value_in;
      end else if (pending_valid) begin
        shown <= pending;
      end
      pending_valid <= 1'b0;
    end else if (value_we) begin
      pending       <= value_in;
      pending_valid <= 1'b1;
    end
  end

  always_comb begin
    nibble = 4'd0;
    blank  = 1'b0;
    case (dig_idx)
      2'd0: nibble = shown[3:0];
      2'd1: begin
        nibble = shown[7:4];
        blank  = blank_en && (shown[12:4] == '0);
      end
      2'd2: begin
        nibble = shown[11:8];
        blank  = blank_en && (shown[12:8] == '0);
      end
      2'd3: begin
        nibble = {3'b000, shown[12]};
        blank  = blank_en && !shown[12];
      end
    endcase
  end

  hex7_decode u_hex7_decode (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n       <= 4'b1111;
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an_n       <= ~(4'b0001 << dig_idx);
      seg_n      <= blank ? SEG_BLANK : hex_seg;
      dp_n       <= ~dp_mask[dig_idx];
      frame_tick <= wrapped;
    end
  end

endmodule
